// File: rtl/riscv_pkg.sv
// Shared register-file writeback definitions: widths, load funct3 encodings,
// and the writeback entry record.
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int NREGS  = 1 << REG_AW;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/load_extend.sv
// Byte/half extraction from an aligned memory word with sign or zero extension.
// Any funct3 that is not a byte or half load passes the whole word through.
module load_extend
    import riscv_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic [W-1:0] ld_word,
    input  logic [2:0]   ld_funct3,
    input  logic [1:0]   ld_offset,
    output logic [W-1:0] ld_result
);

    logic [W-1:0] byte_sh;
    logic [W-1:0] half_sh;

    always_comb begin
        byte_sh = ld_word >> {ld_offset, 3'b000};
        // Halves are selected by offset[1] only; misaligned halves are not split.
        half_sh = ld_word >> {ld_offset[1], 4'b0000};
        case (ld_funct3)
            F3_LB:   ld_result = {{(W-8){byte_sh[7]}}, byte_sh[7:0]};
            F3_LBU:  ld_result = {{(W-8){1'b0}}, byte_sh[7:0]};
            F3_LH:   ld_result = {{(W-16){half_sh[15]}}, half_sh[15:0]};
            F3_LHU:  ld_result = {{(W-16){1'b0}}, half_sh[15:0]};
            default: ld_result = ld_word;
        endcase
    end

endmodule

// File: rtl/reg_writeback.sv
// Register-file write master: arbitrates ALU and load results (load first),
// queues them in order and drains one per cycle, exporting per-register busy bits.
module reg_writeback
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = riscv_pkg::XLEN
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [REG_AW-1:0]        alu_rd,
    input  logic [XLEN-1:0]          alu_data,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [REG_AW-1:0]        ld_rd,
    input  logic [XLEN-1:0]          ld_word,
    input  logic [2:0]               ld_funct3,
    input  logic [1:0]               ld_offset,
    input  logic                     stall,
    output logic                     wen,
    output logic [REG_AW-1:0]        rd,
    output logic [XLEN-1:0]          din,
    output logic [NREGS-1:0]         busy,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [REG_AW-1:0] mem_rd_q   [DEPTH];
    logic [REG_AW-1:0] mem_rd_d   [DEPTH];
    logic [XLEN-1:0]   mem_data_q [DEPTH];
    logic [XLEN-1:0]   mem_data_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              full, empty;
    logic              ld_fire, alu_fire, push, pop;
    logic [REG_AW-1:0] push_rd;
    logic [XLEN-1:0]   push_data;
    logic [XLEN-1:0]   ld_ext;
    logic [PTR_W-1:0]  slot_off;

    load_extend #(.W(XLEN)) u_load_extend (
        .ld_word   (ld_word),
        .ld_funct3 (ld_funct3),
        .ld_offset (ld_offset),
        .ld_result (ld_ext)
    );

    always_comb begin
        full      = (count_q == FULL_CNT);
        empty     = (count_q == '0);
        ld_ready  = !rst && !full;
        alu_ready = !rst && !full && !ld_valid;
        ld_fire   = ld_valid && ld_ready;
        alu_fire  = alu_valid && alu_ready;
        push_rd   = ld_fire ? ld_rd  : alu_rd;
        push_data = ld_fire ? ld_ext : alu_data;
        // x0 results still complete the handshake but never occupy a slot.
        push      = (ld_fire || alu_fire) && (push_rd != '0);
        wen       = !rst && !empty && !stall;
        pop       = wen;
        rd        = empty ? '0 : mem_rd_q[rd_ptr_q];
        din       = empty ? '0 : mem_data_q[rd_ptr_q];
        count     = count_q;
    end

    always_comb begin
        mem_rd_d   = mem_rd_q;
        mem_data_d = mem_data_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) begin
            mem_rd_d[wr_ptr_q]   = push_rd;
            mem_data_d[wr_ptr_q] = push_data;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        busy     = '0;
        slot_off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_off = PTR_W'(i) - rd_ptr_q;
            if ({1'b0, slot_off} < count_q)
                busy[mem_rd_q[i]] = 1'b1;
        end
        busy[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_rd_q[i]   <= '0;
                mem_data_q[i] <= '0;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            mem_rd_q   <= mem_rd_d;
            mem_data_q <= mem_data_d;
        end
    end

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback and the standalone load_extend block.
module tb_reg_writeback;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid, ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_word;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_offset;
    logic        stall;
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] din;
    logic [31:0] busy;
    logic [2:0]  count;

    logic [31:0] le_word;
    logic [2:0]  le_f3;
    logic [1:0]  le_off;
    logic [31:0] le_res;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_writeback #(.DEPTH(4), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_word(ld_word),
        .ld_funct3(ld_funct3), .ld_offset(ld_offset),
        .stall(stall), .wen(wen), .rd(rd), .din(din), .busy(busy), .count(count)
    );

    load_extend #(.W(32)) u_le (
        .ld_word(le_word), .ld_funct3(le_f3), .ld_offset(le_off), .ld_result(le_res)
    );

    typedef struct {
        logic [31:0] word;
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] exp;
    } le_vec_t;

    le_vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        ld_valid = 0; ld_rd = 0; ld_word = 0; ld_funct3 = 0; ld_offset = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{32'h80FF7F01, 3'b000, 2'd3, 32'hFFFFFF80};
        vecs[1]  = '{32'h80FF7F01, 3'b100, 2'd3, 32'h00000080};
        vecs[2]  = '{32'h80FF7F01, 3'b001, 2'd2, 32'hFFFF80FF};
        vecs[3]  = '{32'h80FF7F01, 3'b101, 2'd0, 32'h00007F01};
        vecs[4]  = '{32'h80FF7F01, 3'b001, 2'd1, 32'h00007F01};
        vecs[5]  = '{32'h80FF7F01, 3'b000, 2'd0, 32'h00000001};
        vecs[6]  = '{32'h80FF7F01, 3'b000, 2'd2, 32'hFFFFFFFF};
        vecs[7]  = '{32'h80FF7F01, 3'b100, 2'd1, 32'h0000007F};
        vecs[8]  = '{32'h80FF7F01, 3'b101, 2'd3, 32'h000080FF};
        vecs[9]  = '{32'h80FF7F01, 3'b010, 2'd3, 32'h80FF7F01};
        vecs[10] = '{32'h80FF7F01, 3'b111, 2'd1, 32'h80FF7F01};
        vecs[11] = '{32'h0000FF80, 3'b001, 2'd0, 32'hFFFFFF80};

        idle_inputs();
        stall = 0;
        le_word = 0; le_f3 = 0; le_off = 0;

        // reset state, readies low while rst high
        rst = 1;
        step();
        alu_valid = 1; alu_rd = 5'd9; alu_data = 32'h1; ld_valid = 1; ld_rd = 5'd9;
        #1;
        check("alu_ready_in_rst", {31'b0, alu_ready}, 32'h0);
        check("ld_ready_in_rst", {31'b0, ld_ready}, 32'h0);
        step();
        idle_inputs();
        rst = 0;
        #1;
        check("rst_count", {29'b0, count}, 32'h0);
        check("rst_wen", {31'b0, wen}, 32'h0);
        check("rst_rd", {27'b0, rd}, 32'h0);
        check("rst_din", din, 32'h0);
        check("rst_busy", busy, 32'h0);

        // standalone extraction table
        for (int i = 0; i < 12; i++) begin
            le_word = vecs[i].word; le_f3 = vecs[i].f3; le_off = vecs[i].off;
            #1;
            check($sformatf("le_vec%0d", i), le_res, vecs[i].exp);
        end

        // 1: single ALU result
        alu_valid = 1; alu_rd = 5'd10; alu_data = 32'hBABEFACE;
        #1;
        check("t1_alu_ready", {31'b0, alu_ready}, 32'h1);
        step();
        idle_inputs();
        #1;
        check("t1_wen", {31'b0, wen}, 32'h1);
        check("t1_rd", {27'b0, rd}, 32'd10);
        check("t1_din", din, 32'hBABEFACE);
        check("t1_busy", busy, 32'h0000_0400);
        check("t1_count", {29'b0, count}, 32'd1);
        step();
        check("t1_wen_after", {31'b0, wen}, 32'h0);
        check("t1_busy_after", busy, 32'h0);

        // 2: load priority over ALU
        ld_valid = 1; ld_rd = 5'd2; ld_word = 32'h12345678; ld_funct3 = F3_LW; ld_offset = 2'd1;
        alu_valid = 1; alu_rd = 5'd3; alu_data = 32'hA5A5A5A5;
        #1;
        check("t2_ld_ready", {31'b0, ld_ready}, 32'h1);
        check("t2_alu_blocked", {31'b0, alu_ready}, 32'h0);
        step();
        ld_valid = 0;
        #1;
        check("t2_alu_ready", {31'b0, alu_ready}, 32'h1);
        check("t2_wen1", {31'b0, wen}, 32'h1);
        check("t2_rd1", {27'b0, rd}, 32'd2);
        check("t2_din1", din, 32'h12345678);
        step();
        idle_inputs();
        #1;
        check("t2_count_pushpop", {29'b0, count}, 32'd1);
        check("t2_wen2", {31'b0, wen}, 32'h1);
        check("t2_rd2", {27'b0, rd}, 32'd3);
        check("t2_din2", din, 32'hA5A5A5A5);
        check("t2_busy2", busy, 32'h0000_0008);
        step();
        check("t2_drained", {31'b0, wen}, 32'h0);

        // 3: extraction through the top-level load path
        ld_valid = 1; ld_rd = 5'd5; ld_word = 32'h80FF7F01; ld_funct3 = F3_LB; ld_offset = 2'd3;
        step();
        idle_inputs();
        #1;
        check("t3_lb_rd", {27'b0, rd}, 32'd5);
        check("t3_lb_din", din, 32'hFFFFFF80);
        ld_valid = 1; ld_rd = 5'd6; ld_word = 32'h80FF7F01; ld_funct3 = F3_LHU; ld_offset = 2'd2;
        step();
        idle_inputs();
        #1;
        check("t3_lhu_din", din, 32'h000080FF);
        step();

        // 4: x0 accepted but dropped
        alu_valid = 1; alu_rd = 5'd0; alu_data = 32'hDEADBEEF;
        #1;
        check("t4_alu_ready", {31'b0, alu_ready}, 32'h1);
        step();
        idle_inputs();
        #1;
        check("t4_count", {29'b0, count}, 32'h0);
        check("t4_wen", {31'b0, wen}, 32'h0);
        check("t4_busy", busy, 32'h0);
        step();
        check("t4_wen_later", {31'b0, wen}, 32'h0);

        // 5: fill under stall, blocked fifth attempt, in-order drain with wrap
        stall = 1;
        for (int i = 1; i <= 4; i++) begin
            alu_valid = 1; alu_rd = 5'(i); alu_data = 32'h11 * i;
            step();
        end
        alu_valid = 1; alu_rd = 5'd5; alu_data = 32'h55;
        ld_valid = 1; ld_rd = 5'd6; ld_word = 32'h66; ld_funct3 = F3_LW;
        #1;
        check("t5_count_full", {29'b0, count}, 32'd4);
        check("t5_ld_ready_full", {31'b0, ld_ready}, 32'h0);
        check("t5_alu_ready_full", {31'b0, alu_ready}, 32'h0);
        check("t5_busy", busy, 32'h0000_001E);
        check("t5_wen_stalled", {31'b0, wen}, 32'h0);
        step();
        idle_inputs();
        #1;
        check("t5_count_held", {29'b0, count}, 32'd4);
        stall = 0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            check($sformatf("t5_wen%0d", i), {31'b0, wen}, 32'h1);
            check($sformatf("t5_rd%0d", i), {27'b0, rd}, 32'(i));
            check($sformatf("t5_din%0d", i), din, 32'h11 * i);
            step();
        end
        check("t5_count_empty", {29'b0, count}, 32'h0);
        check("t5_busy_empty", busy, 32'h0);

        // 6: reset discards queued entries
        stall = 1;
        for (int i = 7; i <= 9; i++) begin
            alu_valid = 1; alu_rd = 5'(i); alu_data = 32'hC0DE0000 + 32'(i);
            step();
        end
        idle_inputs();
        #1;
        check("t6_count_pre", {29'b0, count}, 32'd3);
        check("t6_busy_pre", busy, 32'h0000_0380);
        rst = 1;
        step();
        rst = 0;
        #1;
        check("t6_count", {29'b0, count}, 32'h0);
        check("t6_busy", busy, 32'h0);
        check("t6_wen", {31'b0, wen}, 32'h0);
        stall = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("t6_nowrite%0d", i), {31'b0, wen}, 32'h0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
